// File: rtl/iter_alu_pkg.sv
// Shared definitions for the iterative ALU: opcodes, FSM states and the
// most-negative-integer helper used by the divide overflow check.
package iter_alu_pkg;

    localparam logic [4:0] OP_ADD    = 5'd1;
    localparam logic [4:0] OP_SUB    = 5'd2;
    localparam logic [4:0] OP_AND    = 5'd3;
    localparam logic [4:0] OP_OR     = 5'd4;
    localparam logic [4:0] OP_XOR    = 5'd5;
    localparam logic [4:0] OP_SLL    = 5'd6;
    localparam logic [4:0] OP_SRL    = 5'd7;
    localparam logic [4:0] OP_SRA    = 5'd8;
    localparam logic [4:0] OP_SLT    = 5'd9;
    localparam logic [4:0] OP_SLTU   = 5'd10;
    localparam logic [4:0] OP_MUL    = 5'd11;
    localparam logic [4:0] OP_MULH   = 5'd12;
    localparam logic [4:0] OP_MULHSU = 5'd13;
    localparam logic [4:0] OP_MULHU  = 5'd14;
    localparam logic [4:0] OP_DIV    = 5'd15;
    localparam logic [4:0] OP_DIVU   = 5'd16;
    localparam logic [4:0] OP_REM    = 5'd17;
    localparam logic [4:0] OP_REMU   = 5'd18;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } state_t;

    // Widest supported XLEN is 64; callers keep the low XLEN bits.
    function automatic logic [63:0] min_int(input int xlen);
        return 64'd1 << (xlen - 1);
    endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Radix-2 multiply / restoring divide engine sharing one 2*XLEN register.
// hi/lo present the sign-corrected result of the iteration now in progress.
module iter_muldiv #(
    parameter int XLEN = 32,
    parameter int CW   = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            start_mul,
    input  logic            start_div,
    input  logic            a_signed,
    input  logic            b_signed,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    logic [2*XLEN-1:0] acc, acc_next, prod_fix;
    logic [XLEN-1:0]   mcand, a_mag, b_mag, q_fix, r_fix, div_sub;
    logic [XLEN:0]     mul_sum, div_shift;
    logic [CW-1:0]     count;
    logic              active, is_div, neg_q, neg_r, a_neg, b_neg, div_ge;

    assign a_neg = a_signed & a[XLEN-1];
    assign b_neg = b_signed & b[XLEN-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // Multiply: add multiplicand into the upper half when the low bit is set,
    // then shift right. Divide: shift the remainder left, subtract if it fits.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_ge    = div_shift >= {1'b0, mcand};
        div_sub   = div_shift[XLEN-1:0] - mcand;
        acc_next  = {mul_sum, acc[XLEN-1:1]};
        if (is_div) begin
            acc_next = div_ge ? {div_sub, acc[XLEN-2:0], 1'b1}
                              : {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end
    end

    assign prod_fix = neg_q ? -acc_next : acc_next;
    assign q_fix    = neg_q ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
    assign r_fix    = neg_r ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
    assign hi       = is_div ? r_fix : prod_fix[2*XLEN-1:XLEN];
    assign lo       = is_div ? q_fix : prod_fix[XLEN-1:0];
    assign done     = active && (count == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            count  <= '0;
            active <= 1'b0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else if (flush) begin
            active <= 1'b0;
        end else if (start_mul || start_div) begin
            active <= 1'b1;
            count  <= CW'(XLEN - 1);
            is_div <= start_div;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            acc    <= {{XLEN{1'b0}}, (start_div ? a_mag : b_mag)};
            mcand  <= start_div ? b_mag : a_mag;
        end else if (active) begin
            acc <= acc_next;
            if (count == '0) begin
                active <= 1'b0;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/iter_alu.sv
// Multi-cycle RV32IM ALU: base ops and divide special cases finish in one
// registered cycle, multiply/divide run XLEN iterations in iter_muldiv.
module iter_alu
    import iter_alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            ready,
    output logic            result_valid,
    output logic [XLEN-1:0] result,
    output logic            br_eq,
    output logic            br_lt,
    output logic            br_ltu
);

    localparam logic [63:0]     MIN_W = min_int(XLEN);
    localparam logic [XLEN-1:0] MIN_V = MIN_W[XLEN-1:0];

    state_t          state, state_n;
    logic [4:0]      op_q;
    logic [XLEN-1:0] base_res, md_res, md_hi, md_lo;
    logic [SHW-1:0]  shamt;
    logic            is_mul, is_div, div_zero, div_ovf, special, accept, base_path;
    logic            a_signed, b_signed, start_mul, start_div, md_done;

    assign shamt     = b[SHW-1:0];
    assign is_mul    = (op >= OP_MUL) && (op <= OP_MULHU);
    assign is_div    = (op >= OP_DIV) && (op <= OP_REMU);
    assign div_zero  = (b == '0);
    assign div_ovf   = ((op == OP_DIV) || (op == OP_REM)) && (a == MIN_V) && (b == '1);
    assign special   = is_div && (div_zero || div_ovf);
    assign accept    = (state == ST_IDLE) && start && !flush;
    assign base_path = !(is_mul || (is_div && !special));
    assign a_signed  = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    assign b_signed  = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);

    assign ready        = (state == ST_IDLE);
    assign result_valid = (state == ST_DONE);

    // Single-cycle results, including the divide-by-zero and overflow answers.
    always_comb begin
        base_res = '0;
        case (op)
            OP_ADD:           base_res = a + b;
            OP_SUB:           base_res = a - b;
            OP_AND:           base_res = a & b;
            OP_OR:            base_res = a | b;
            OP_XOR:           base_res = a ^ b;
            OP_SLL:           base_res = a << shamt;
            OP_SRL:           base_res = a >> shamt;
            OP_SRA:           base_res = $signed(a) >>> shamt;
            OP_SLT:           base_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU:          base_res = {{(XLEN-1){1'b0}}, (a < b)};
            OP_DIV, OP_DIVU:  base_res = div_zero ? '1 : MIN_V;
            OP_REM, OP_REMU:  base_res = div_zero ? a : '0;
            default:          base_res = '0;
        endcase
    end

    always_comb begin
        md_res = md_lo;
        case (op_q)
            OP_MULH, OP_MULHSU, OP_MULHU, OP_REM, OP_REMU: md_res = md_hi;
            default:                                       md_res = md_lo;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        start_mul = 1'b0;
        start_div = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (is_mul) begin
                        state_n   = ST_MUL;
                        start_mul = 1'b1;
                    end else if (is_div && !special) begin
                        state_n   = ST_DIV;
                        start_div = 1'b1;
                    end else begin
                        state_n = ST_DONE;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                if (flush) begin
                    state_n = ST_IDLE;
                end else if (md_done) begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // A flushed op leaves result and the branch flags from the last accepted op.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result <= '0;
            op_q   <= '0;
            br_eq  <= 1'b0;
            br_lt  <= 1'b0;
            br_ltu <= 1'b0;
        end else if (accept) begin
            op_q   <= op;
            br_eq  <= (a == b);
            br_lt  <= ($signed(a) < $signed(b));
            br_ltu <= (a < b);
            if (base_path) begin
                result <= base_res;
            end
        end else if (!flush && ((state == ST_MUL) || (state == ST_DIV)) && md_done) begin
            result <= md_res;
        end
    end

    iter_muldiv #(
        .XLEN (XLEN),
        .CW   (SHW)
    ) u_muldiv (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .start_mul (start_mul),
        .start_div (start_div),
        .a_signed  (a_signed),
        .b_signed  (b_signed),
        .a         (a),
        .b         (b),
        .done      (md_done),
        .hi        (md_hi),
        .lo        (md_lo)
    );

endmodule

// File: tb/tb_iter_alu.sv
// Scoreboard bench for iter_alu at XLEN=32: expectations come from a 64-bit
// reference model and are popped whenever result_valid is seen.
module tb_iter_alu;
    import iter_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [4:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        ready, result_valid, br_eq, br_lt, br_ltu;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        logic        eq;
        logic        lt;
        logic        ltu;
        int          lat;
        int          acc_cyc;
        logic [4:0]  op;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    iter_alu #(.XLEN(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .flush        (flush),
        .op           (op),
        .a            (a),
        .b            (b),
        .ready        (ready),
        .result_valid (result_valid),
        .result       (result),
        .br_eq        (br_eq),
        .br_lt        (br_lt),
        .br_ltu       (br_ltu)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] ss, su;
        logic [63:0]        uu;
        logic [4:0]         sh;
        sh = y[4:0];
        ss = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
        su = $signed({{32{x[31]}}, x}) * $signed({32'd0, y});
        uu = {32'd0, x} * {32'd0, y};
        case (o)
            OP_ADD:    return x + y;
            OP_SUB:    return x - y;
            OP_AND:    return x & y;
            OP_OR:     return x | y;
            OP_XOR:    return x ^ y;
            OP_SLL:    return x << sh;
            OP_SRL:    return x >> sh;
            OP_SRA:    return $signed(x) >>> sh;
            OP_SLT:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            OP_SLTU:   return (x < y) ? 32'd1 : 32'd0;
            OP_MUL:    return uu[31:0];
            OP_MULH:   return ss[63:32];
            OP_MULHSU: return su[63:32];
            OP_MULHU:  return uu[63:32];
            OP_DIV: begin
                if (y == 32'd0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
                return $signed(x) / $signed(y);
            end
            OP_DIVU:   return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
            OP_REM: begin
                if (y == 32'd0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
                return $signed(x) % $signed(y);
            end
            OP_REMU:   return (y == 32'd0) ? x : x % y;
            default:   return 32'd0;
        endcase
    endfunction

    function automatic bit is_long(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o >= OP_MUL && o <= OP_MULHU) return 1'b1;
        if (o >= OP_DIV && o <= OP_REMU) begin
            if (y == 32'd0) return 1'b0;
            if ((o == OP_DIV || o == OP_REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1'b0;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // Scoreboard: every completion must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n && result_valid) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_completion: result_valid=1 result=%h, required no completion", result);
            end else begin
                mon_e = sb.pop_front();
                if (result !== mon_e.res) begin
                    miscompares++;
                    $display("[TB] FAIL result op=%0d: got %h, expected %h", mon_e.op, result, mon_e.res);
                end
                vectors++;
                if ({br_eq, br_lt, br_ltu} !== {mon_e.eq, mon_e.lt, mon_e.ltu}) begin
                    miscompares++;
                    $display("[TB] FAIL branch_flags op=%0d: got %b, expected %b", mon_e.op,
                             {br_eq, br_lt, br_ltu}, {mon_e.eq, mon_e.lt, mon_e.ltu});
                end
                vectors++;
                if (cyc - mon_e.acc_cyc + 1 != mon_e.lat) begin
                    miscompares++;
                    $display("[TB] FAIL latency op=%0d: got %0d, expected %0d", mon_e.op,
                             cyc - mon_e.acc_cyc + 1, mon_e.lat);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output bit done_ok, output bit busy_ok);
        exp_t e;
        int   n;
        n = 0;
        while (ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        op = o; a = x; b = y; start = 1'b1;
        e.res = model(o, x, y);
        e.eq = (x == y);
        e.lt = ($signed(x) < $signed(y));
        e.ltu = (x < y);
        e.lat = is_long(o, x, y) ? 33 : 1;
        e.acc_cyc = cyc + 1;
        e.op = o;
        sb.push_back(e);
        done_ok = 1'b0;
        busy_ok = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (sb.size() == 0) begin
                done_ok = 1'b1;
                break;
            end
            if (ready !== 1'b0) busy_ok = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready: got %b, expected 1", ready); end
        vectors++;
        if (result_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b, expected 0", result_valid); end
        vectors++;
        if (result !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_result: got %h, expected 0", result); end
        vectors++;
        if ({br_eq, br_lt, br_ltu} !== 3'b000) begin
            miscompares++; $display("[TB] FAIL reset_br: got %b, expected 000", {br_eq, br_lt, br_ltu});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_base();
        logic [4:0]  ops[12] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL,
                                 OP_SRL, OP_SRA, OP_SLT, OP_SLTU, 5'd0, 5'd25};
        logic [31:0] as[12]  = '{32'h7FFF_FFFF, 32'd5, 32'hF0F0_1234, 32'h0F00_0001, 32'hAAAA_5555, 32'd1,
                                 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd9, 32'd9};
        logic [31:0] bs[12]  = '{32'd1, 32'd7, 32'hFF00_FF00, 32'h00F0_0010, 32'hFFFF_0000, 32'h0000_003F,
                                 32'd4, 32'h21, 32'd1, 32'd1, 32'd9, 32'd3};
        logic [31:0] ex[12]  = '{32'h8000_0000, 32'hFFFF_FFFE, 32'hF000_1200, 32'h0FF0_0011, 32'h5555_5555,
                                 32'h8000_0000, 32'h0800_0000, 32'hC000_0000, 32'd1, 32'd0, 32'd0, 32'd0};
        bit d, bz;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(ops[i], as[i], bs[i], d, bz);
            vectors++;
            if (!d || result !== ex[i]) begin
                miscompares++;
                $display("[TB] FAIL base_op%0d: got %h (done=%b), expected %h", ops[i], result, d, ex[i]);
            end
        end
    endtask

    task automatic test_mul();
        logic [4:0]  ops[5] = '{OP_MULH, OP_MULHU, OP_MUL, OP_MULHSU, OP_MULH};
        logic [31:0] as[5]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] bs[5]  = '{32'd2, 32'd2, 32'hFFFF_FFFB, 32'd2, 32'h8000_0000};
        logic [31:0] ex[5]  = '{32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFF1, 32'hFFFF_FFFF, 32'h4000_0000};
        bit d, bz;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(ops[i], as[i], bs[i], d, bz);
            vectors++;
            if (!d || result !== ex[i]) begin
                miscompares++;
                $display("[TB] FAIL mul_op%0d: got %h (done=%b), expected %h", ops[i], result, d, ex[i]);
            end
            vectors++;
            if (!bz) begin
                miscompares++;
                $display("[TB] FAIL mul_busy_op%0d: ready seen high while busy, expected low", ops[i]);
            end
        end
    endtask

    task automatic test_div();
        logic [4:0]  ops[6] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM};
        logic [31:0] as[6]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7, 32'd7, 32'd7};
        logic [31:0] bs[6]  = '{32'd2, 32'd2, 32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
        logic [31:0] ex[6]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd3, 32'd1, 32'hFFFF_FFFD, 32'd1};
        bit d, bz;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(ops[i], as[i], bs[i], d, bz);
            vectors++;
            if (!d || result !== ex[i]) begin
                miscompares++;
                $display("[TB] FAIL div_op%0d: got %h (done=%b), expected %h", ops[i], result, d, ex[i]);
            end
        end
    endtask

    task automatic test_special();
        logic [4:0]  ops[6] = '{OP_DIV, OP_REMU, OP_DIV, OP_REM, OP_DIVU, OP_REM};
        logic [31:0] as[6]  = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'hFFFF_FFF0};
        logic [31:0] bs[6]  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [31:0] ex[6]  = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF0};
        bit d, bz;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(ops[i], as[i], bs[i], d, bz);
            vectors++;
            if (!d || result !== ex[i]) begin
                miscompares++;
                $display("[TB] FAIL special_op%0d: got %h (done=%b), expected %h", ops[i], result, d, ex[i]);
            end
        end
    endtask

    task automatic test_flush();
        bit d, bz, seen;
        applyStimulus(OP_ADD, 32'h11, 32'h22, d, bz);
        while (ready !== 1'b1) @(negedge clk);
        op = OP_MUL; a = 32'd1234; b = 32'd5678; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        vectors++;
        if (ready !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_ready: got %b, expected 1", ready); end
        vectors++;
        if (result !== 32'h33) begin miscompares++; $display("[TB] FAIL flush_result: got %h, expected 00000033", result); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (result_valid === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (seen) begin miscompares++; $display("[TB] FAIL flush_no_valid: got result_valid=1, expected 0"); end
        op = OP_ADD; a = 32'd9; b = 32'd9; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        vectors++;
        if (result_valid !== 1'b0 || ready !== 1'b1) begin
            miscompares++; $display("[TB] FAIL flush_start: got valid=%b ready=%b, expected valid=0 ready=1", result_valid, ready);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (result !== 32'h33 || br_eq !== 1'b0 || result_valid !== 1'b0) begin
            miscompares++; $display("[TB] FAIL flush_start_state: got result=%h br_eq=%b valid=%b, expected 00000033 0 0",
                                    result, br_eq, result_valid);
        end
    endtask

    task automatic test_busy();
        bit d, bz;
        fork
            applyStimulus(OP_DIVU, 32'd100, 32'd7, d, bz);
            begin
                repeat (5) @(negedge clk);
                #2;
                op = OP_ADD; a = 32'd1; b = 32'd1; start = 1'b1;
                @(negedge clk);
                #2;
                start = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        #1;
        vectors++;
        if (result !== 32'd14 || br_eq !== 1'b0 || ready !== 1'b1) begin
            miscompares++; $display("[TB] FAIL busy_start: got result=%h br_eq=%b ready=%b, expected 0000000e 0 1",
                                    result, br_eq, ready);
        end
    endtask

    task automatic test_back_to_back();
        bit d, bz;
        applyStimulus(OP_ADD, 32'd2, 32'd2, d, bz);
        op = OP_SUB; a = 32'd10; b = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        vectors++;
        if (ready !== 1'b1 || result !== 32'd4 || result_valid !== 1'b0) begin
            miscompares++; $display("[TB] FAIL done_start: got ready=%b result=%h valid=%b, expected 1 00000004 0",
                                    ready, result, result_valid);
        end
        repeat (3) @(negedge clk);
        applyStimulus(OP_ADD, 32'd40, 32'd2, d, bz);
        applyStimulus(OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, d, bz);
        applyStimulus(OP_REM, 32'hFFFF_FF9C, 32'd7, d, bz);
        vectors++;
        if (!d || result !== 32'hFFFF_FFFE) begin
            miscompares++; $display("[TB] FAIL back_to_back_rem: got %h (done=%b), expected fffffffe", result, d);
        end
    endtask

    task automatic test_reset_mid();
        bit d, bz;
        while (ready !== 1'b1) @(negedge clk);
        op = OP_DIV; a = 32'hFFFF_FF9C; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (result !== 32'd0 || {br_eq, br_lt, br_ltu} !== 3'b000) begin
            miscompares++; $display("[TB] FAIL midreset_state: got result=%h br=%b, expected 0 000", result, {br_eq, br_lt, br_ltu});
        end
        vectors++;
        if (ready !== 1'b1 || result_valid !== 1'b0) begin
            miscompares++; $display("[TB] FAIL midreset_ctrl: got ready=%b valid=%b, expected 1 0", ready, result_valid);
        end
        applyStimulus(OP_ADD, 32'd2, 32'd3, d, bz);
        vectors++;
        if (!d || result !== 32'd5) begin
            miscompares++; $display("[TB] FAIL midreset_add: got %h (done=%b), expected 00000005", result, d);
        end
        repeat (40) @(negedge clk);
    endtask

    task automatic test_random();
        bit          d, bz;
        logic [4:0]  o;
        logic [31:0] x, y;
        for (int i = 0; i < 30; i++) begin
            o = 5'($urandom_range(0, 20));
            x = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 3))
                0:       y = 32'd0;
                1:       y = 32'hFFFF_FFFF;
                2:       y = 32'($urandom_range(1, 40));
                default: y = $urandom;
            endcase
            applyStimulus(o, x, y, d, bz);
            vectors++;
            if (!d) begin
                miscompares++; $display("[TB] FAIL random_timeout op=%0d a=%h b=%h: no completion, expected one", o, x, y);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_base();
        test_mul();
        test_div();
        test_special();
        test_flush();
        test_busy();
        test_back_to_back();
        test_reset_mid();
        test_random();
        repeat (5) @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++; $display("[TB] FAIL outstanding: got %0d pending results, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
